// File: rtl/clk_div_gen.sv
// clk_div_gen: NCH-channel run-time programmable clock divider with one-cycle edge ticks.
// Optional macro CLKDIV_SYNC_EN adds a sync input that phase-aligns all channels.
module clk_div_gen #(
  parameter int NCH     = 2,
  parameter int CW      = 8,
  parameter int DEF_DIV = 9,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef CLKDIV_SYNC_EN
  input  logic           sync,
`endif
  input  logic [NCH-1:0] en,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pend
);

  typedef enum logic [1:0] {IDLE, RUN, RUN_PEND} ch_state_t;

  logic [CW-1:0]  cnt      [NCH];
  logic [CW-1:0]  div_act  [NCH];
  logic [CW-1:0]  div_nxt  [NCH];
  logic [CW-1:0]  cnt_d    [NCH];
  logic [CW-1:0]  div_act_d[NCH];
  logic [CW-1:0]  div_nxt_d[NCH];
  logic [NCH-1:0] pend_d;
  logic [NCH-1:0] clk_out_d;
  logic [NCH-1:0] tick_d;
  logic [NCH-1:0] acc;
  logic [CW-1:0]  div_in;
  ch_state_t      st       [NCH];

  // Out-of-range channel numbers are always ready and the write is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++)
      if (cfg_ch == CHW'(i)) cfg_ready = ~pend[i];
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NCH; i++)
      acc[i] = cfg_valid && cfg_ready && (cfg_ch == CHW'(i));
  end

  assign div_in = (cfg_div == '0) ? CW'(1) : cfg_div;

  always_comb begin
    pend_d    = pend;
    clk_out_d = clk_out;
    tick_d    = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]     = cnt[i];
      div_act_d[i] = div_act[i];
      div_nxt_d[i] = div_nxt[i];
      if (!en[i])       st[i] = IDLE;
      else if (pend[i]) st[i] = RUN_PEND;
      else              st[i] = RUN;

      case (st[i])
        IDLE: begin
          if (pend[i]) begin
            div_act_d[i] = div_nxt[i];
            cnt_d[i]     = '0;
            pend_d[i]    = 1'b0;
          end
        end
        RUN, RUN_PEND: begin
          if (cnt[i] == div_act[i] - CW'(1)) begin
            cnt_d[i]     = '0;
            clk_out_d[i] = ~clk_out[i];
            tick_d[i]    = 1'b1;
            // A pending ratio only lands on a half-period boundary.
            if (st[i] == RUN_PEND) begin
              div_act_d[i] = div_nxt[i];
              pend_d[i]    = 1'b0;
            end
          end else begin
            cnt_d[i] = cnt[i] + CW'(1);
          end
        end
        default: ;
      endcase

`ifdef CLKDIV_SYNC_EN
      if (sync) begin
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
        tick_d[i]    = 1'b0;
        if (pend[i]) begin
          div_act_d[i] = div_nxt[i];
          pend_d[i]    = 1'b0;
        end
      end
`endif

      // Acceptance implies pend was clear, so it never races an apply.
      if (acc[i]) begin
        div_nxt_d[i] = div_in;
        pend_d[i]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]     <= '0;
        div_act[i] <= CW'(DEF_DIV);
        div_nxt[i] <= CW'(DEF_DIV);
      end
      pend    <= '0;
      clk_out <= '0;
      tick    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]     <= cnt_d[i];
        div_act[i] <= div_act_d[i];
        div_nxt[i] <= div_nxt_d[i];
      end
      pend    <= pend_d;
      clk_out <= clk_out_d;
      tick    <= tick_d;
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen (default build): vector table, directed corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_clk_div_gen;
  localparam int NCH = 3, CW = 8, DEF_DIV = 9, CHW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic [NCH-1:0] clk_out, tick, pend;

  always #5 clk = ~clk;

  clk_div_gen #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  int checks = 0, errors = 0;

  // Reference model: edges elapsed in the current half-period, and the ratios.
  int             m_el [NCH];
  int             m_half [NCH];
  int             m_nxt [NCH];
  logic [NCH-1:0] m_pnd, m_out, m_tk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_el[i] = 0; m_half[i] = DEF_DIV; m_nxt[i] = DEF_DIV;
    end
    m_pnd = '0; m_out = '0; m_tk = '0;
  endtask

  function automatic logic model_ready();
    if (int'(cfg_ch) >= NCH) return 1'b1;
    return !m_pnd[cfg_ch];
  endfunction

  task automatic model_edge();
    logic rdy;
    rdy = model_ready();
    for (int i = 0; i < NCH; i++) begin
      m_tk[i] = 1'b0;
      if (en[i]) begin
        m_el[i]++;
        if (m_el[i] >= m_half[i]) begin
          m_el[i] = 0;
          m_out[i] = ~m_out[i];
          m_tk[i] = 1'b1;
          if (m_pnd[i]) begin m_half[i] = m_nxt[i]; m_pnd[i] = 1'b0; end
        end
      end else if (m_pnd[i]) begin
        m_half[i] = m_nxt[i]; m_el[i] = 0; m_pnd[i] = 1'b0;
      end
      if (cfg_valid && rdy && int'(cfg_ch) == i) begin
        m_nxt[i] = (cfg_div == 0) ? 1 : int'(cfg_div);
        m_pnd[i] = 1'b1;
      end
    end
  endtask

  // One clock: inputs already driven; outputs compared on the falling edge.
  task automatic step();
    #1 chk("cfg_ready", cfg_ready, model_ready());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("clk_out", clk_out, m_out);
    chk("tick", tick, m_tk);
    chk("pend", pend, m_pnd);
  endtask

  task automatic do_reset();
    en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ready", cfg_ready, 1);
  endtask

  task automatic edges_to_tick(input int ch, output int n);
    n = 0;
    do begin step(); n++; end while (!tick[ch] && n < 40);
  endtask

  typedef struct {
    logic [NCH-1:0] en;
    logic           v;
    logic [CHW-1:0] ch;
    logic [CW-1:0]  dv;
    logic           rdy;
    logic [NCH-1:0] o, t, p;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tbl[0] = '{3'b000, 1'b1, 2'd0, 8'd2, 1'b1, 3'b000, 3'b000, 3'b001};
    tbl[1] = '{3'b000, 1'b1, 2'd1, 8'd0, 1'b1, 3'b000, 3'b000, 3'b010};
    tbl[2] = '{3'b000, 1'b1, 2'd1, 8'd3, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[3] = '{3'b011, 1'b0, 2'd1, 8'd0, 1'b1, 3'b010, 3'b010, 3'b000};
    tbl[4] = '{3'b011, 1'b0, 2'd1, 8'd0, 1'b1, 3'b001, 3'b011, 3'b000};
    tbl[5] = '{3'b011, 1'b0, 2'd1, 8'd0, 1'b1, 3'b011, 3'b010, 3'b000};
    tbl[6] = '{3'b001, 1'b1, 2'd3, 8'd7, 1'b1, 3'b010, 3'b001, 3'b000};
    tbl[7] = '{3'b001, 1'b0, 2'd0, 8'd0, 1'b1, 3'b010, 3'b000, 3'b000};

    do_reset();
    for (int k = 0; k < 8; k++) begin
      en = tbl[k].en; cfg_valid = tbl[k].v; cfg_ch = tbl[k].ch; cfg_div = tbl[k].dv;
      #1 chk($sformatf("tbl%0d_ready", k), cfg_ready, tbl[k].rdy);
      step();
      chk($sformatf("tbl%0d_clk_out", k), clk_out, tbl[k].o);
      chk($sformatf("tbl%0d_tick", k), tick, tbl[k].t);
      chk($sformatf("tbl%0d_pend", k), pend, tbl[k].p);
    end

    // Defaults: first rise on edge 9, ticks every 9 edges.
    do_reset();
    en = 3'b011;
    n = 0;
    do begin step(); n++; end while (!clk_out[0] && n < 40);
    chk("dflt_first_rise", n, 9);
    chk("dflt_both_high", clk_out[1:0], 2'b11);
    edges_to_tick(0, n);
    chk("dflt_half_period", n, 9);

    // Update while running: old half-period completes, then the new one applies.
    do_reset();
    en = 3'b001;
    repeat (3) step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
    step();
    cfg_valid = 1'b0;
    chk("run_pend_set", pend[0], 1);
    #1 chk("run_ready_low", cfg_ready, 0);
    edges_to_tick(0, n);
    chk("run_old_half", n, 5);
    chk("run_pend_clr", pend[0], 0);
    edges_to_tick(0, n);
    chk("run_new_half_a", n, 4);
    edges_to_tick(0, n);
    chk("run_new_half_b", n, 4);

    // Divisor 0 on an idle channel becomes 1 and applies one cycle later.
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0;
    step();
    cfg_valid = 1'b0;
    chk("idle_pend_set", pend[1], 1);
    step();
    chk("idle_pend_clr", pend[1], 0);
    en = 3'b010;
    step();
    chk("div1_first", clk_out[1], 1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("div1_tick_cont", tick[1], 1);
      chk("div1_toggle", clk_out[1], k[0]);
    end

    // Accept on the wrap edge: old ratio is used for that wrap.
    do_reset();
    en = 3'b001;
    repeat (8) step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
    step();
    cfg_valid = 1'b0;
    chk("wrap_acc_tick", tick[0], 1);
    chk("wrap_acc_pend", pend[0], 1);
    edges_to_tick(0, n);
    chk("wrap_acc_old", n, 9);
    edges_to_tick(0, n);
    chk("wrap_acc_new", n, 3);

    // Asynchronous reset mid-half-period with an update pending.
    do_reset();
    en = 3'b011;
    repeat (11) step();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    chk("pre_rst_out", clk_out, 3'b011);
    chk("pre_rst_pend", pend, 3'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", clk_out, 0);
    chk("async_rst_tick", tick, 0);
    chk("async_rst_pend", pend, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin step(); n++; end while (!clk_out[0] && n < 40);
    chk("post_rst_rise", n, 9);
    chk("post_rst_ch1", clk_out[1], 1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_ch    = CHW'($urandom_range(0, 3));
      cfg_div   = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 255))
                                              : CW'($urandom_range(0, 6));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
